// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module  : stopwatch_pkg
// Brief   : Shared state encoding and default timing constants for the
//           stopwatch control front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam int unsigned DEF_HALF_DIV   = 50_000_000;
  localparam int unsigned DEF_DEB_CYCLES = 1_000_000;
  localparam int unsigned DEF_CNT_W      = 27;

  function automatic logic is_legal(input state_e s);
    return (s == ST_COUNT) || (s == ST_PAUSED) || (s == ST_ADJUST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module  : stopwatch_ctrl_if
// Brief   : Board-side raw inputs and datapath-side strobes/qualifiers of the
//           stopwatch control block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;

  logic       sel_raw;
  logic       adj_raw;
  logic       pause_raw;
  logic       clr_raw;
  logic       lap_raw;

  logic       sec_inc;
  logic       min_inc;
  logic       carry_en;
  logic       clr;
  logic       blink_sec;
  logic       blink_min;
  logic       disp_hold;
  logic [1:0] mode;

  // Board / datapath side
  modport master (
    output sel_raw, adj_raw, pause_raw, clr_raw, lap_raw,
    input  sec_inc, min_inc, carry_en, clr, blink_sec, blink_min,
           disp_hold, mode
  );

  // Control block side
  modport slave (
    input  sel_raw, adj_raw, pause_raw, clr_raw, lap_raw,
    output sec_inc, min_inc, carry_en, clr, blink_sec, blink_min,
           disp_hold, mode
  );

endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-FF synchroniser, consecutive-sample debouncer and one-cycle
//           rising-edge pulse for a single board input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic raw_i,
  output logic      level_o,
  output logic      rise_o
);

  localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic              sync1_q;
  logic              sync2_q;
  logic              level_q;
  logic              level_d;
  logic              level_dly_q;
  logic              rise_q;
  logic [DCNT_W-1:0] cnt_q;
  logic [DCNT_W-1:0] cnt_d;

  // Count only while the synchronised sample disagrees; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DCNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module  : stopwatch_ctrl
// Brief   : Input conditioning, COUNT/PAUSED/ADJUST mode machine and strobe
//           generation for the stopwatch digit datapath.
//           Optional lap/display-hold feature: define STOPWATCH_LAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned HALF_DIV   = DEF_HALF_DIV,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input wire logic        clk,
  input wire logic        rst,
  stopwatch_ctrl_if.slave sw
);

  logic sel_lvl, sel_rise;
  logic adj_lvl, adj_rise;
  logic pause_lvl, pause_pulse;
  logic clr_lvl, clr_pulse;
  logic lap_pulse;
  logic unused_w;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst(rst), .raw_i(sw.sel_raw), .level_o(sel_lvl), .rise_o(sel_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk(clk), .rst(rst), .raw_i(sw.adj_raw), .level_o(adj_lvl), .rise_o(adj_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk(clk), .rst(rst), .raw_i(sw.pause_raw), .level_o(pause_lvl), .rise_o(pause_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst(rst), .raw_i(sw.clr_raw), .level_o(clr_lvl), .rise_o(clr_pulse)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_lvl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .raw_i(sw.lap_raw), .level_o(lap_lvl), .rise_o(lap_pulse)
  );

  assign unused_w = ^{sel_rise, adj_rise, pause_lvl, clr_lvl, lap_lvl};
`else
  assign lap_pulse = 1'b0;
  assign unused_w  = ^{sel_rise, adj_rise, pause_lvl, clr_lvl, lap_pulse, sw.lap_raw};
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             phase_q, phase_d;
  logic             tick1, tick2;

  logic sec_inc_q,   sec_inc_d;
  logic min_inc_q,   min_inc_d;
  logic carry_en_q,  carry_en_d;
  logic clr_q,       clr_d;
  logic blink_sec_q, blink_sec_d;
  logic blink_min_q, blink_min_d;
  logic disp_hold_q, disp_hold_d;

  assign tick2 = (presc_q == CNT_W'(HALF_DIV - 1));
  assign tick1 = tick2 & phase_q;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q + 1'b1;
    phase_d     = phase_q;
    sec_inc_d   = 1'b0;
    min_inc_d   = 1'b0;
    carry_en_d  = 1'b0;
    clr_d       = clr_pulse;
    blink_sec_d = 1'b0;
    blink_min_d = 1'b0;
    disp_hold_d = disp_hold_q;

    if (tick2) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
    // Clear restarts the half-second timebase so the next tick1 is a full second away.
    if (clr_pulse) begin
      presc_d = '0;
      phase_d = 1'b0;
    end

    case (state_q)
      ST_COUNT: begin
        if (adj_lvl)          state_d = ST_ADJUST;
        else if (pause_pulse) state_d = ST_PAUSED;
        sec_inc_d = tick1;
      end
      ST_PAUSED: begin
        if (adj_lvl)          state_d = ST_ADJUST;
        else if (pause_pulse) state_d = ST_COUNT;
      end
      ST_ADJUST: begin
        state_d   = adj_lvl ? ST_ADJUST : ST_PAUSED;
        sec_inc_d = tick2 & sel_lvl;
        min_inc_d = tick2 & ~sel_lvl;
      end
      default: begin
        state_d = ST_PAUSED;
      end
    endcase

    if (!is_legal(state_q)) begin
      state_d = ST_PAUSED;
    end

    if (clr_pulse) begin
      sec_inc_d = 1'b0;
      min_inc_d = 1'b0;
    end

    carry_en_d  = (state_d == ST_COUNT);
    blink_sec_d = (state_d == ST_ADJUST) &  sel_lvl & phase_d;
    blink_min_d = (state_d == ST_ADJUST) & ~sel_lvl & phase_d;

`ifdef STOPWATCH_LAP_EN
    if (clr_pulse || (state_d == ST_ADJUST)) begin
      disp_hold_d = 1'b0;
    end else if (lap_pulse) begin
      if (state_q == ST_COUNT)       disp_hold_d = ~disp_hold_q;
      else if (state_q == ST_PAUSED) disp_hold_d = 1'b0;
    end
`else
    disp_hold_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PAUSED;
      presc_q     <= '0;
      phase_q     <= 1'b0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      carry_en_q  <= 1'b0;
      clr_q       <= 1'b0;
      blink_sec_q <= 1'b0;
      blink_min_q <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      carry_en_q  <= carry_en_d;
      clr_q       <= clr_d;
      blink_sec_q <= blink_sec_d;
      blink_min_q <= blink_min_d;
      disp_hold_q <= disp_hold_d;
    end
  end

  assign sw.sec_inc   = sec_inc_q;
  assign sw.min_inc   = min_inc_q;
  assign sw.carry_en  = carry_en_q;
  assign sw.clr       = clr_q;
  assign sw.blink_sec = blink_sec_q;
  assign sw.blink_min = blink_min_q;
  assign sw.disp_hold = disp_hold_q;
  assign sw.mode      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module  : tb_stopwatch_ctrl
// Brief   : Scoreboard bench for stopwatch_ctrl against a behavioural model
//           (HALF_DIV=4, DEB_CYCLES=3). Honours STOPWATCH_LAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int H = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raw_v;   // {lap, clr, pause, adj, sel}

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl_if swif ();

  assign swif.sel_raw   = raw_v[0];
  assign swif.adj_raw   = raw_v[1];
  assign swif.pause_raw = raw_v[2];
  assign swif.clr_raw   = raw_v[3];
  assign swif.lap_raw   = raw_v[4];

  stopwatch_ctrl #(.HALF_DIV(H), .DEB_CYCLES(D), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (swif.slave)
  );

  always #5 clk = ~clk;

  // Expected output word: {mode[1:0], disp_hold, blink_min, blink_sec, clr, carry_en, min_inc, sec_inc}
  logic [8:0] exp_q[$];
  bit         m_started = 1'b0;

  logic [4:0] raw_hist[$];
  logic [4:0] samp_hist[$];
  logic [4:0] lvl_hist[$];
  logic [4:0] m_lvl;
  int         m_e = 0;
  int         m_b = 0;
  int         m_state = 1;
  bit         m_hold = 1'b0;

  // Reference model: debounce as "last D delayed samples all disagree", timebase as
  // arithmetic on edges elapsed since the last reset/clear.
  always @(posedge clk) begin
    logic [4:0] lvl_new, pls;
    bit         all_diff, t2, t1, ph_after, sel, adj, clrp, pausep, lapp, s_inc, m_inc;
    int         k, ns;
    m_e = m_e + 1;
    if (rst) begin
      raw_hist  = {5'd0, 5'd0};
      samp_hist = {};
      lvl_hist  = {5'd0, 5'd0, 5'd0};
      m_lvl     = '0;
      m_b       = m_e + 1;
      m_state   = 1;
      m_hold    = 1'b0;
      exp_q.push_back({2'd1, 7'd0});
    end else begin
      raw_hist.push_back(raw_v);
      samp_hist.push_back(raw_hist[raw_hist.size() - 3]);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
      if (samp_hist.size() > D) void'(samp_hist.pop_front());

      lvl_new = m_lvl;
      for (int i = 0; i < 5; i++) begin
        all_diff = (samp_hist.size() == D);
        for (int j = 0; j < samp_hist.size(); j++)
          if (samp_hist[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) lvl_new[i] = ~m_lvl[i];
      end

      pls    = lvl_hist[1] & ~lvl_hist[0];
      sel    = lvl_hist[2][0];
      adj    = lvl_hist[2][1];
      pausep = pls[2];
      clrp   = pls[3];
      lapp   = pls[4];

      k  = m_e - m_b;
      t2 = ((k % H) == H - 1);
      t1 = t2 && (((k / H) % 2) == 1);

      if (adj)               ns = 2;
      else if (m_state == 2) ns = 1;
      else if (pausep)       ns = (m_state == 0) ? 1 : 0;
      else                   ns = m_state;

      s_inc = !clrp && (((m_state == 0) && t1) || ((m_state == 2) && t2 && sel));
      m_inc = !clrp && (m_state == 2) && t2 && !sel;

      if (clrp) m_b = m_e + 1;
      ph_after = (((m_e + 1 - m_b) / H) % 2) == 1;

`ifdef STOPWATCH_LAP_EN
      if (clrp || ns == 2)  m_hold = 1'b0;
      else if (lapp) begin
        if (m_state == 0)      m_hold = !m_hold;
        else if (m_state == 1) m_hold = 1'b0;
      end
`else
      m_hold = 1'b0;
      lapp   = 1'b0;
`endif

      exp_q.push_back({2'(ns), m_hold,
                       (ns == 2) && !sel && ph_after,
                       (ns == 2) && sel && ph_after,
                       clrp, (ns == 0), m_inc, s_inc});
      m_state = ns;
      m_lvl   = lvl_new;
      void'(lvl_hist.pop_front());
      lvl_hist.push_back(lvl_new);
    end
    m_started = 1'b1;
  end

  // Monitor: one expected word per registered output cycle
  always @(negedge clk) begin
    logic [8:0] got, exp;
    got = {swif.mode, swif.disp_hold, swif.blink_min, swif.blink_sec,
           swif.clr, swif.carry_en, swif.min_inc, swif.sec_inc};
    if (exp_q.size() == 0) begin
      if (m_started) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underrun t=%0t got=%b required=an expected entry", $time, got);
      end
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t got mode=%0d hold=%b bmin=%b bsec=%b clr=%b carry=%b min=%b sec=%b required mode=%0d hold=%b bmin=%b bsec=%b clr=%b carry=%b min=%b sec=%b",
                 $time, got[8:7], got[6], got[5], got[4], got[3], got[2], got[1], got[0],
                 exp[8:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int n);
    raw_v[b] = 1'b1;
    idle(n);
    raw_v[b] = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    raw_v = '0;
    idle(3);
    rst = 1'b0;
    idle(40);

    press(2, 10);  idle(40);   // PAUSED -> COUNT
    press(2, 10);  idle(20);   // COUNT -> PAUSED
    press(2, 2);   idle(20);   // glitch, ignored

    raw_v[1] = 1'b1; raw_v[0] = 1'b1; idle(40);
    raw_v[0] = 1'b0; idle(40);
    raw_v[1] = 1'b0; idle(20);

    press(2, 10);  idle(20);   // back to COUNT
    for (int k = 0; k < 8; k++) begin
      idle(k);
      press(3, 5);
      idle(27);
    end

    press(4, 5); idle(20);
    press(4, 5); idle(20);
    press(4, 5); idle(10);
    raw_v[1] = 1'b1; idle(20);
    raw_v[1] = 1'b0; idle(20);

    repeat (300) begin
      int b, n;
      b = $urandom_range(0, 4);
      n = $urandom_range(1, 8);
      if (b < 2) begin
        raw_v[b] = ~raw_v[b];
        idle(3 * n);
      end else begin
        press(b, n);
        idle($urandom_range(0, 6));
      end
    end

    raw_v = '0;
    idle(10);
    rst = 1'b1; idle(2); rst = 1'b0;
    idle(15);
    press(2, 6); idle(30);

    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
